// File: rtl/cla_pkg.sv
// Shared 16-bit carry-lookahead helpers used by the CLA adder and subtractor datapaths.
package cla_pkg;

  localparam int unsigned SEG_W = 16;

  // Carry into bit idx of a 16-bit segment in flat sum-of-products form; idx = SEG_W is the carry-out.
  function automatic logic cla16_carry_at(input int idx, input logic cin,
                                          input logic [SEG_W-1:0] g,
                                          input logic [SEG_W-1:0] p);
    logic c;
    logic t;
    t = cin;
    for (int j = 0; j < int'(SEG_W); j++) begin
      if (j < idx) t = t & p[j];
    end
    c = t;
    for (int i = 0; i < int'(SEG_W); i++) begin
      if (i < idx) begin
        t = g[i];
        for (int j = i + 1; j < int'(SEG_W); j++) begin
          if (j < idx) t = t & p[j];
        end
        c = c | t;
      end
    end
    return c;
  endfunction

  // 16-term lookahead carry-out of a segment.
  function automatic logic cla16_cout(input logic cin, input logic [SEG_W-1:0] g,
                                      input logic [SEG_W-1:0] p);
    return cla16_carry_at(int'(SEG_W), cin, g, p);
  endfunction

  // Segment sum vector: each bit is its propagate XOR the lookahead carry into it.
  function automatic logic [SEG_W-1:0] cla16_sum(input logic cin, input logic [SEG_W-1:0] g,
                                                 input logic [SEG_W-1:0] p);
    logic [SEG_W-1:0] s;
    s = '0;
    for (int i = 0; i < int'(SEG_W); i++) begin
      s[i] = p[i] ^ cla16_carry_at(i, cin, g, p);
    end
    return s;
  endfunction

endpackage

// File: rtl/cla_sub_seg16.sv
// One 16-bit subtract segment: a + ~b + cin with lookahead carries.
module cla_sub_seg16
  import cla_pkg::*;
(
  input  logic [SEG_W-1:0] a_seg,
  input  logic [SEG_W-1:0] b_seg,
  input  logic             cin,
  output logic [SEG_W-1:0] s_seg,
  output logic             cout,
  output logic             c_msb
);

  logic [SEG_W-1:0] w_g;
  logic [SEG_W-1:0] w_p;

  // Generate/propagate in the borrow direction (subtrahend inverted).
  assign w_g   = a_seg & ~b_seg;
  assign w_p   = a_seg ^ ~b_seg;

  assign s_seg = cla16_sum(cin, w_g, w_p);
  assign cout  = cla16_cout(cin, w_g, w_p);
  assign c_msb = cla16_carry_at(int'(SEG_W) - 1, cin, w_g, w_p);

endmodule

// File: rtl/cla_sub_pipe.sv
// Pipelined subtractor diff = a - b - bin; one 16-bit segment resolved per stage,
// inter-segment carry registered. WIDTH must be a multiple of 16 with at least two segments.
module cla_sub_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned SEG       = SEG_W;
  localparam int unsigned STAGES    = WIDTH / SEG;
  // Stage k keeps SEG*(k+1) diff bits; all stages are packed into one vector.
  localparam int unsigned DIFF_BITS = SEG * STAGES * (STAGES + 1) / 2;
  // Stage k (k < STAGES-1) keeps WIDTH-SEG*(k+1) unresolved operand bits.
  localparam int unsigned REM_BITS  = (STAGES - 1) * WIDTH - SEG * (STAGES - 1) * STAGES / 2;
  localparam int unsigned LAST_DOFF = SEG * (STAGES - 1) * STAGES / 2;

  logic [STAGES-1:0]    r_v;
  logic [STAGES-1:0]    w_adv;
  logic [STAGES-2:0]    r_c;
  logic [DIFF_BITS-1:0] r_diff;
  logic [REM_BITS-1:0]  r_ra;
  logic [REM_BITS-1:0]  r_rb;
  logic                 r_bout;
  logic                 r_ovf;

  genvar k;

  // A stage may advance when it is empty or every stage downstream of it can advance.
  for (k = 0; k < STAGES; k++) begin : gen_adv
    assign w_adv[k] = out_ready | ~(&r_v[STAGES-1:k]);
  end

  assign in_ready  = w_adv[0] & ~rst;
  assign out_valid = r_v[STAGES-1];
  assign diff      = r_diff[LAST_DOFF +: WIDTH];
  assign bout      = r_bout;
  assign ovf       = r_ovf;

  for (k = 0; k < STAGES; k++) begin : gen_stage
    localparam int unsigned DW   = SEG * (k + 1);
    localparam int unsigned DOFF = SEG * k * (k + 1) / 2;
    localparam int unsigned SW   = WIDTH - SEG * k;

    logic [SW-1:0]  w_src_a;
    logic [SW-1:0]  w_src_b;
    logic [SEG-1:0] w_s;
    logic           w_cin;
    logic           w_cout;
    logic           w_cmsb;
    logic           w_vin;
    logic [DW-1:0]  w_dnext;

    if (k == 0) begin : g_first
      assign w_src_a = a;
      assign w_src_b = b;
      assign w_cin   = ~bin;
      assign w_vin   = in_valid & in_ready;
      assign w_dnext = w_s;
    end else begin : g_next
      localparam int unsigned PDOFF = SEG * (k - 1) * k / 2;
      localparam int unsigned PROFF = (k - 1) * WIDTH - SEG * (k - 1) * k / 2;
      assign w_src_a = r_ra[PROFF +: SW];
      assign w_src_b = r_rb[PROFF +: SW];
      assign w_cin   = r_c[k-1];
      assign w_vin   = r_v[k-1];
      assign w_dnext = {w_s, r_diff[PDOFF +: SEG * k]};
    end

    cla_sub_seg16 u_seg (
      .a_seg (w_src_a[SEG-1:0]),
      .b_seg (w_src_b[SEG-1:0]),
      .cin   (w_cin),
      .s_seg (w_s),
      .cout  (w_cout),
      .c_msb (w_cmsb)
    );

    // Valid bit and accumulated diff bits; a stalled stage holds.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_v[k]              <= 1'b0;
        r_diff[DOFF +: DW]  <= '0;
      end else if (w_adv[k]) begin
        r_v[k]              <= w_vin;
        r_diff[DOFF +: DW]  <= w_dnext;
      end
    end

    if (k < STAGES - 1) begin : g_carry
      localparam int unsigned RW   = WIDTH - SEG * (k + 1);
      localparam int unsigned ROFF = k * WIDTH - SEG * k * (k + 1) / 2;

      // Only the final segment's carry into its MSB matters for overflow.
      logic w_unused_cmsb;
      assign w_unused_cmsb = w_cmsb;

      // Segment carry-out and the operand bits still to be resolved.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_c[k]             <= 1'b0;
          r_ra[ROFF +: RW]   <= '0;
          r_rb[ROFF +: RW]   <= '0;
        end else if (w_adv[k]) begin
          r_c[k]             <= w_cout;
          r_ra[ROFF +: RW]   <= w_src_a[SW-1:SEG];
          r_rb[ROFF +: RW]   <= w_src_b[SW-1:SEG];
        end
      end
    end else begin : g_last
      // Borrow-out is the inverted final carry; overflow compares carries into and out of the MSB.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_bout <= 1'b0;
          r_ovf  <= 1'b0;
        end else if (w_adv[k]) begin
          r_bout <= ~w_cout;
          r_ovf  <= w_cmsb ^ w_cout;
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Bench for cla_sub_pipe: directed vectors plus an arithmetic reference model with a scoreboard.
module tb_cla_sub_pipe;

  localparam int unsigned W   = 64;
  localparam int unsigned WX  = W + 2;
  localparam int unsigned NST = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  exp_t q[$];
  exp_t held;
  exp_t m_e;
  logic stall_prev;
  int   total;
  int   bad;
  int   n_pop;

  logic [W-1:0] va [8] = '{64'h0000_0000_0001_0000, 64'h1234_5678_9ABC_DEF0,
                           64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000,
                           64'h8000_0000_0000_0000, 64'h0000_0001_0000_0000,
                           64'h7FFF_0000_0000_0000, 64'hDEAD_BEEF_0000_0000};
  logic [W-1:0] vb [8] = '{64'h0000_0000_0000_0001, 64'h0FED_CBA9_8765_4321,
                           64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000,
                           64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001,
                           64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001};
  logic         vc [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  cla_sub_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer subtraction in a wider word, then range checks.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [WX-1:0] us;
    logic [WX-1:0] ss;
    exp_t m;
    us   = {2'b00, x} - {2'b00, y} - WX'(c);
    ss   = {{2{x[W-1]}}, x} - {{2{y[W-1]}}, y} - WX'(c);
    m.d  = us[W-1:0];
    m.bo = us[WX-1];
    m.ov = (ss[WX-1:W-1] != 3'b000) && (ss[WX-1:W-1] != 3'b111);
    return m;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, expv);
    end
  endtask

  // Scoreboard: checks in_ready, output hold while stalled, and every delivered result.
  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready_in_reset", W'(in_ready), W'(1'b0));
      q.delete();
      stall_prev = 1'b0;
    end else begin
      chk("in_ready", W'(in_ready), W'((q.size() < NST) || out_ready));
      if (stall_prev) begin
        chk("hold_valid", W'(out_valid), W'(1'b1));
        chk("hold_diff", diff, held.d);
        chk("hold_bout", W'(bout), W'(held.bo));
        chk("hold_ovf", W'(ovf), W'(held.ov));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_result: got diff %h with nothing outstanding", diff);
        end else begin
          m_e = q.pop_front();
          chk("result_diff", diff, m_e.d);
          chk("result_bout", W'(bout), W'(m_e.bo));
          chk("result_ovf", W'(ovf), W'(m_e.ov));
          n_pop++;
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = {diff, bout, ovf};
      if (in_valid && in_ready) q.push_back(model(a, b, bin));
    end
  end

  // Single operation into an empty pipe; checks latency and hand-computed result.
  task automatic run_one(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                         input logic tc, input logic [W-1:0] ed, input logic ebo,
                         input logic eov);
    int   lat;
    exp_t got;
    lat = -1;
    got = '0;
    @(posedge clk); #1;
    a = ta; b = tbv; bin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (out_valid && lat < 0) begin
        lat = n;
        got = {diff, bout, ovf};
      end
    end
    chk({nm, "_latency"}, W'(lat), W'(3));
    chk({nm, "_diff"}, got.d, ed);
    chk({nm, "_bout"}, W'(got.bo), W'(ebo));
    chk({nm, "_ovf"}, W'(got.ov), W'(eov));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent;
    int pop0;
    int seen;
    total = 0; bad = 0; n_pop = 0; stall_prev = 1'b0; held = '0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; bin = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", W'(out_valid), W'(1'b0));
    chk("reset_diff", diff, '0);
    chk("reset_bout", W'(bout), W'(1'b0));
    chk("reset_ovf", W'(ovf), W'(1'b0));
    chk("reset_in_ready", W'(in_ready), W'(1'b0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", W'(in_ready), W'(1'b1));

    run_one("basic", 64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0);
    run_one("underflow", 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run_one("borrow_chain", 64'h0001_0000_0000_0000, 64'd0, 1'b1,
            64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_one("ovf_neg", 64'h8000_0000_0000_0000, 64'd1, 1'b0,
            64'h7FFF_FFFF_FFFF_FFFF, 1'b1 ^ 1'b1, 1'b1);
    run_one("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
            64'h8000_0000_0000_0000, 1'b1, 1'b1);
    run_one("ones_bin", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run_one("zeros", 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);

    // Backpressure: 8 back-to-back ops, consumer stalls for cycles 5..9.
    sent = 0;
    pop0 = n_pop;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      out_ready = !(i >= 5 && i <= 9);
      if (sent < 8) begin
        in_valid = 1'b1; a = va[sent]; b = vb[sent]; bin = vc[sent];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i == 5) chk("bp_in_ready_full", W'(in_ready), W'(1'b0));
      if (i >= 10 && i <= 16) chk("bp_throughput", W'(out_valid), W'(1'b1));
      if (in_valid && in_ready) sent++;
    end
    chk("bp_all_sent", W'(sent), W'(8));
    chk("bp_all_out", W'(n_pop - pop0), W'(8));

    // Reset with three operations in flight and a fourth offered during reset.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = va[i]; b = vb[i]; bin = vc[i];
    end
    @(posedge clk); #1;
    in_valid = 1'b1; a = va[3]; b = vb[3]; bin = vc[3]; rst = 1'b1;
    @(negedge clk);
    chk("rst_no_accept", W'(in_ready), W'(1'b0));
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", W'(out_valid), W'(1'b0));
    chk("flush_diff", diff, '0);
    chk("flush_bout", W'(bout), W'(1'b0));
    chk("flush_ovf", W'(ovf), W'(1'b0));
    chk("flush_in_ready", W'(in_ready), W'(1'b1));
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush_no_results", W'(seen), W'(0));

    run_one("after_flush", 64'h0000_0001_0000_0000, 64'd1, 1'b0,
            64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0);

    chk("scoreboard_empty", W'(q.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
